signal_stable_detect: RTL and testbench

Trigger-path conditioner between the analog comparator pin and the ADC double-buffer capture stage. It synchronises the asynchronous comparator square wave into clk and measures its period in clk cycles. It raises `stable` once the period has held within tolerance for a configurable number of consecutive cycles. Its `sync_signal_out`/`stable` pair directly drives the capture stage's `sync_signal_in`/`stable` inputs; `period` is exported for MCU readback.

---
 rtl/trig_pkg.sv | 12 +
 rtl/sync_edge_detect.sv | 31 +++
 rtl/signal_stable_detect.sv | 148 ++++++++++++++
 tb/tb_signal_stable_detect.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trig_pkg.sv
// Shared types for the comparator trigger path.
// The FSM state encoding is common to the period tracker and its consumers.
package trig_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TRACK   = 2'd2,
    LOCKED  = 2'd3
  } trig_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous pin with a registered rising-edge pulse.
// Reusable for any slow asynchronous MCU or comparator input.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/signal_stable_detect.sv
// Comparator trigger conditioner: synchronises the pin, measures its period in clk cycles
// and asserts stable once the period holds within tolerance for STABLE_COUNT periods.
module signal_stable_detect
  import trig_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_WIDTH    = 20,
  parameter int MIN_PERIOD   = 4,
  parameter int MAX_PERIOD   = 1000000,
  parameter int TOL_SHIFT    = 5,
  parameter int STABLE_COUNT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 signal_in,
  output logic                 sync_signal_out,
  output logic                 stable,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
  output logic                 timeout
);

  localparam int                   MC_W    = $clog2(STABLE_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_PERIOD);
  localparam logic [CNT_WIDTH:0]   MIN_M   = (CNT_WIDTH + 1)'(MIN_PERIOD);
  localparam logic [MC_W-1:0]      MC_LOCK = MC_W'(STABLE_COUNT);

  logic rise;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(signal_in),
    .level   (sync_signal_out),
    .rise    (rise)
  );

  trig_state_t          state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] ref_q, ref_d;
  logic [MC_W-1:0]      mc_q, mc_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 valid_d, timeout_d, stable_d;

  // Period arithmetic carries one extra bit so m = cnt+1 and |m - ref| never wrap.
  logic [CNT_WIDTH:0]   m_ext, ref_ext, diff, tol;
  logic [CNT_WIDTH-1:0] m;
  logic                 is_match, is_glitch, at_max;

  always_comb begin
    m_ext     = {1'b0, cnt_q} + (CNT_WIDTH + 1)'(1);
    ref_ext   = {1'b0, ref_q};
    diff      = (m_ext >= ref_ext) ? (m_ext - ref_ext) : (ref_ext - m_ext);
    tol       = ref_ext >> TOL_SHIFT;
    is_match  = (diff <= tol);
    is_glitch = (m_ext < MIN_M);
    at_max    = (cnt_q == CNT_MAX);
    m         = m_ext[CNT_WIDTH-1:0];
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_d     = ref_q;
    mc_d      = mc_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      mc_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          mc_d  = '0;
          if (rise) state_d = MEASURE;
        end
        MEASURE, TRACK, LOCKED: begin
          if (at_max) begin
            // Loss of signal takes priority over a coincident edge.
            timeout_d = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
            mc_d      = '0;
          end else if (rise && !is_glitch) begin
            cnt_d = '0;
            if (state_q == MEASURE) begin
              ref_d    = m;
              period_d = m;
              valid_d  = 1'b1;
              mc_d     = '0;
              state_d  = TRACK;
            end else if (is_match) begin
              period_d = m;
              valid_d  = 1'b1;
              if (state_q == TRACK) begin
                mc_d = mc_q + MC_W'(1);
                if (mc_q + MC_W'(1) == MC_LOCK) state_d = LOCKED;
              end
            end else begin
              // Reference follows only a mismatching period, never a matching one.
              ref_d   = m;
              mc_d    = '0;
              state_d = TRACK;
            end
          end else begin
            cnt_d = at_max ? cnt_q : cnt_q + CNT_WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    stable_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ref_q        <= '0;
      mc_q         <= '0;
      period_q     <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      stable       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ref_q        <= ref_d;
      mc_q         <= mc_d;
      period_q     <= period_d;
      period_valid <= valid_d;
      timeout      <= timeout_d;
      stable       <= stable_d;
    end
  end

  assign period = period_q;

endmodule

// File: tb/tb_signal_stable_detect.sv
// Directed bench for signal_stable_detect: table-driven lock/tolerance run plus
// hand-written glitch, timeout, enable and asynchronous-reset sequences.
module tb_signal_stable_detect;

  localparam int CW   = 20;
  localparam int MAXP = 400;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          signal_in;
  logic          sync_signal_out;
  logic          stable;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          timeout;

  always #5 clk = ~clk;

  signal_stable_detect #(
    .SYNC_STAGES (2),
    .CNT_WIDTH   (CW),
    .MIN_PERIOD  (4),
    .MAX_PERIOD  (MAXP),
    .TOL_SHIFT   (5),
    .STABLE_COUNT(4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .signal_in      (signal_in),
    .sync_signal_out(sync_signal_out),
    .stable         (stable),
    .period         (period),
    .period_valid   (period_valid),
    .timeout        (timeout)
  );

  int checks     = 0;
  int failures   = 0;
  int valid_seen = 0;
  int to_seen    = 0;

  typedef struct {
    int   p;
    logic ev;
    int   eper;
    logic est;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (period_valid) valid_seen++;
    if (timeout) to_seen++;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  // One pin period of p cycles starting with a rising edge; samples outputs
  // 3 and 4 cycles after the edge (SYNC_STAGES+2 = 4 is the update point).
  task automatic pin_period(input int p, output logic v3, output logic st3,
                            output logic v4, output logic st4, output logic [CW-1:0] per4);
    signal_in = 1'b1;
    hold(3);
    v3  = period_valid;
    st3 = stable;
    tick();
    v4   = period_valid;
    st4  = stable;
    per4 = period;
    hold(p / 2 - 4);
    signal_in = 1'b0;
    hold(p - p / 2);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    en        = 1'b1;
    signal_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      signal_in = ~signal_in;
      tick();
    end
    signal_in = 1'b0;
    tick();
    rst_n      = 1'b1;
    valid_seen = 0;
    to_seen    = 0;
  endtask

  task automatic lock100();
    logic v3, st3, v4, st4;
    logic [CW-1:0] per4;
    for (int i = 0; i < 6; i++) pin_period(100, v3, st3, v4, st4, per4);
    check("lock100_stable", st4, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v3, st3, v4, st4, prev_st;
    logic [CW-1:0] per4;
    logic seen;
    int vs0;

    vecs[0]  = '{100, 1'b0,   0, 1'b0};
    vecs[1]  = '{100, 1'b1, 100, 1'b0};
    vecs[2]  = '{100, 1'b1, 100, 1'b0};
    vecs[3]  = '{100, 1'b1, 100, 1'b0};
    vecs[4]  = '{100, 1'b1, 100, 1'b0};
    vecs[5]  = '{100, 1'b1, 100, 1'b1};
    vecs[6]  = '{103, 1'b1, 100, 1'b1};
    vecs[7]  = '{ 97, 1'b1, 103, 1'b1};
    vecs[8]  = '{104, 1'b1,  97, 1'b1};
    vecs[9]  = '{104, 1'b0,  97, 1'b0};
    vecs[10] = '{104, 1'b1, 104, 1'b0};
    vecs[11] = '{104, 1'b1, 104, 1'b0};
    vecs[12] = '{104, 1'b1, 104, 1'b0};
    vecs[13] = '{104, 1'b1, 104, 1'b1};

    // Reset with toggling pin: everything stays zero.
    rst_n     = 1'b0;
    en        = 1'b1;
    signal_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      signal_in = ~signal_in;
      tick();
    end
    check("rst_sync_out", sync_signal_out, 1'b0);
    check("rst_stable", stable, 1'b0);
    check("rst_period", period, 0);
    check("rst_valid", period_valid, 1'b0);
    check("rst_timeout", timeout, 1'b0);

    // Static pin after release: no pulses, no timeout.
    do_reset();
    hold(2 * MAXP + 10);
    check("idle_timeout_count", to_seen, 0);
    check("idle_valid_count", valid_seen, 0);
    check("idle_stable", stable, 1'b0);

    // Table: lock at 100, tolerance edges 103/97, mismatch at 104, relock at 104.
    do_reset();
    prev_st = 1'b0;
    for (int i = 0; i < 14; i++) begin
      vs0 = valid_seen;
      pin_period(vecs[i].p, v3, st3, v4, st4, per4);
      check($sformatf("vec%0d_valid_early", i), v3, 1'b0);
      check($sformatf("vec%0d_stable_early", i), st3, prev_st);
      check($sformatf("vec%0d_valid", i), v4, vecs[i].ev);
      check($sformatf("vec%0d_stable", i), st4, vecs[i].est);
      check($sformatf("vec%0d_period", i), per4, vecs[i].eper);
      check($sformatf("vec%0d_valid_count", i), valid_seen - vs0, vecs[i].ev ? 1 : 0);
      prev_st = vecs[i].est;
    end

    // Glitch: extra rise 3 cycles after a real rise (m=3 < MIN_PERIOD) is ignored.
    do_reset();
    lock100();
    vs0 = valid_seen;
    signal_in = 1'b1;
    hold(2);
    signal_in = 1'b0;
    hold(1);
    signal_in = 1'b1;
    tick();
    check("glitch_main_valid", period_valid, 1'b1);
    check("glitch_main_period", period, 100);
    hold(46);
    signal_in = 1'b0;
    hold(50);
    check("glitch_valid_count", valid_seen - vs0, 1);
    check("glitch_stable_hold", stable, 1'b1);
    pin_period(100, v3, st3, v4, st4, per4);
    check("post_glitch_valid", v4, 1'b1);
    check("post_glitch_period", per4, 100);
    check("post_glitch_stable", st4, 1'b1);

    // Timeout: pin held low after lock.
    do_reset();
    lock100();
    seen = 1'b0;
    for (int i = 0; i < MAXP + 50; i++) begin
      tick();
      if (timeout) begin
        seen = 1'b1;
        break;
      end
    end
    check("timeout_seen", seen, 1'b1);
    check("timeout_stable", stable, 1'b0);
    check("timeout_period_hold", period, 100);
    tick();
    check("timeout_one_cycle", timeout, 1'b0);
    pin_period(120, v3, st3, v4, st4, per4);
    check("to_measure_valid", v4, 1'b0);
    check("to_measure_stable", st4, 1'b0);
    pin_period(100, v3, st3, v4, st4, per4);
    check("to_track_valid", v4, 1'b1);
    check("to_track_period", per4, 120);
    check("to_track_stable", st4, 1'b0);

    // Enable low for one cycle while locked.
    do_reset();
    lock100();
    signal_in = 1'b1;
    hold(10);
    en = 1'b0;
    tick();
    check("en_low_stable", stable, 1'b0);
    en = 1'b1;
    hold(40);
    signal_in = 1'b0;
    hold(50);
    for (int i = 0; i < 6; i++) begin
      pin_period(100, v3, st3, v4, st4, per4);
      if (i == 0) check("en_first_rise_valid", v4, 1'b0);
      if (i == 4) check("en_relock_not_yet", st4, 1'b0);
      if (i == 5) check("en_relock_stable", st4, 1'b1);
    end

    // Asynchronous reset mid-period: outputs clear without a clock edge.
    do_reset();
    lock100();
    signal_in = 1'b1;
    hold(20);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_stable", stable, 1'b0);
    check("async_rst_period", period, 0);
    check("async_rst_sync_out", sync_signal_out, 1'b0);
    hold(3);
    rst_n      = 1'b1;
    valid_seen = 0;
    to_seen    = 0;
    hold(20);
    check("post_rst_valid_count", valid_seen, 0);
    check("post_rst_timeout_count", to_seen, 0);
    check("post_rst_stable", stable, 1'b0);
    check("post_rst_sync_out", sync_signal_out, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
